// File: rtl/trig_seq_pkg.sv
// trig_seq_pkg: shared types and default widths for the trigger sequencer.
//   trig_seq_state_t : burst sequencing state (IDLE, TRIG, LISTEN, GAP, DONE)
//   CNT_WIDTH_DEF    : default width of phase-length fields and the phase counter
//   BURST_WIDTH_DEF  : default width of the burst-count field and shot index
package trig_seq_pkg;

    localparam int CNT_WIDTH_DEF   = 16;
    localparam int BURST_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TRIG   = 3'd1,
        ST_LISTEN = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } trig_seq_state_t;

endpackage

// File: rtl/trig_sequencer_timer.sv
// phase_timer: tick-driven phase counter shared by every sequencer phase.
// Ports:
//   clk_in   system clock
//   rst_in   synchronous active-low reset
//   clr_in   clear the counter (has priority over tick_in)
//   tick_in  timebase event; counter advances only on this
//   len_in   length of the current phase in ticks (never 0)
//   hit_out  combinational terminal-count pulse: tick on the last count of the phase
module phase_timer
    import trig_seq_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clr_in,
    input  logic                 tick_in,
    input  logic [CNT_WIDTH-1:0] len_in,
    output logic                 hit_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_r;

    // Tick counter: cleared between phases, advanced on each tick within a phase.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_r <= CNT_ZERO;
        end else if (clr_in) begin
            cnt_r <= CNT_ZERO;
        end else if (tick_in) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The phase ends on the tick that would bring the count up to len.
    assign hit_out = tick_in && (cnt_r == (len_in - CNT_ONE));

endmodule

// File: rtl/trig_sequencer.sv
// trig_sequencer: sequences one depth-capture burst of emitter trigger pulse,
// receiver listen window and inter-shot gap, repeated cfg_burst times.
// Phase lengths are counted in tick_in events.
// Ports:
//   clk_in / rst_in            clock, synchronous active-low reset
//   tick_in                    prescaled timebase event
//   cfg_valid_in/cfg_ready_out config handshake (ready is combinational)
//   cfg_*_len_in, cfg_burst_in phase lengths and shots per burst (0 stored as 1)
//   start_in / abort_in        start a burst from IDLE / cancel the burst
//   trig_out, listen_out       high during TRIG / LISTEN
//   busy_out, done_out         not IDLE / one-cycle burst-complete pulse
//   burst_idx_out              0-based index of the current shot
// Optional build macro TRIG_SEQ_CONTINUOUS_EN adds cont_mode_in: when high,
// DONE restarts a new burst instead of returning to IDLE.
module trig_sequencer
    import trig_seq_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   tick_in,
    input  logic                   cfg_valid_in,
    output logic                   cfg_ready_out,
    input  logic [CNT_WIDTH-1:0]   cfg_trig_len_in,
    input  logic [CNT_WIDTH-1:0]   cfg_listen_len_in,
    input  logic [CNT_WIDTH-1:0]   cfg_gap_len_in,
    input  logic [BURST_WIDTH-1:0] cfg_burst_in,
    input  logic                   start_in,
    input  logic                   abort_in,
`ifdef TRIG_SEQ_CONTINUOUS_EN
    input  logic                   cont_mode_in,
`endif
    output logic                   trig_out,
    output logic                   listen_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [BURST_WIDTH-1:0] burst_idx_out
);

    localparam logic [CNT_WIDTH-1:0]   LEN_ONE   = CNT_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] IDX_ZERO  = BURST_WIDTH'(0);

    trig_seq_state_t        state_r, state_s;
    logic [CNT_WIDTH-1:0]   trig_len_r, listen_len_r, gap_len_r, len_s;
    logic [BURST_WIDTH-1:0] burst_r, burst_idx_r, burst_idx_s;
    logic                   trig_r, listen_r, busy_r, done_r;
    logic                   hit_s, clr_s, cfg_fire_s;

    function automatic logic [CNT_WIDTH-1:0] clamp_len(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_WIDTH'(0)) ? LEN_ONE : v;
    endfunction

    function automatic logic [BURST_WIDTH-1:0] clamp_burst(input logic [BURST_WIDTH-1:0] v);
        return (v == BURST_WIDTH'(0)) ? BURST_ONE : v;
    endfunction

    // Start has priority over a config write in the same IDLE cycle.
    assign cfg_ready_out = (state_r == ST_IDLE) && !start_in;
    assign cfg_fire_s    = cfg_ready_out && cfg_valid_in;

    // Select the length of the phase currently being timed.
    always_comb begin
        len_s = trig_len_r;
        case (state_r)
            ST_TRIG:   len_s = trig_len_r;
            ST_LISTEN: len_s = listen_len_r;
            ST_GAP:    len_s = gap_len_r;
            default:   len_s = trig_len_r;
        endcase
    end

    // Counter held clear outside timed phases and restarted at every phase end.
    assign clr_s = (state_r == ST_IDLE) || (state_r == ST_DONE) || hit_s || abort_in;

    phase_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_in  (clr_s),
        .tick_in (tick_in),
        .len_in  (len_s),
        .hit_out (hit_s)
    );

    // Next-state and shot-index logic; abort overrides everything outside IDLE.
    always_comb begin
        state_s     = state_r;
        burst_idx_s = burst_idx_r;
        if (abort_in && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        state_s     = ST_TRIG;
                        burst_idx_s = IDX_ZERO;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_TRIG: begin
                    if (hit_s) begin
                        state_s = ST_LISTEN;
                    end else begin
                        state_s = ST_TRIG;
                    end
                end
                ST_LISTEN: begin
                    if (hit_s) begin
                        if (burst_idx_r == (burst_r - BURST_ONE)) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_GAP;
                        end
                    end else begin
                        state_s = ST_LISTEN;
                    end
                end
                ST_GAP: begin
                    if (hit_s) begin
                        state_s     = ST_TRIG;
                        burst_idx_s = burst_idx_r + BURST_ONE;
                    end else begin
                        state_s = ST_GAP;
                    end
                end
                ST_DONE: begin
`ifdef TRIG_SEQ_CONTINUOUS_EN
                    if (cont_mode_in) begin
                        state_s     = ST_TRIG;
                        burst_idx_s = IDX_ZERO;
                    end else begin
                        state_s = ST_IDLE;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, shot index and outputs; outputs decode the state being entered so
    // they line up exactly with state_r.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r     <= ST_IDLE;
            burst_idx_r <= IDX_ZERO;
            trig_r      <= 1'b0;
            listen_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            burst_idx_r <= burst_idx_s;
            trig_r      <= (state_s == ST_TRIG);
            listen_r    <= (state_s == ST_LISTEN);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
        end
    end

    // Configuration registers, all four latched together on handshake.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            trig_len_r   <= LEN_ONE;
            listen_len_r <= LEN_ONE;
            gap_len_r    <= LEN_ONE;
            burst_r      <= BURST_ONE;
        end else if (cfg_fire_s) begin
            trig_len_r   <= clamp_len(cfg_trig_len_in);
            listen_len_r <= clamp_len(cfg_listen_len_in);
            gap_len_r    <= clamp_len(cfg_gap_len_in);
            burst_r      <= clamp_burst(cfg_burst_in);
        end else begin
            trig_len_r   <= trig_len_r;
            listen_len_r <= listen_len_r;
            gap_len_r    <= gap_len_r;
            burst_r      <= burst_r;
        end
    end

    assign trig_out      = trig_r;
    assign listen_out    = listen_r;
    assign busy_out      = busy_r;
    assign done_out      = done_r;
    assign burst_idx_out = burst_idx_r;

endmodule

// File: tb/tb_trig_sequencer.sv
// tb_trig_sequencer: directed bench for trig_sequencer with a phase/ticks-left
// reference model checked every cycle, plus literal per-scenario expectations.
module tb_trig_sequencer;

    localparam int CW = 16;
    localparam int BW = 8;

    logic          clk_in = 1'b0;
    logic          rst_in, tick_in, cfg_valid_in, start_in, abort_in;
    logic [CW-1:0] cfg_trig_len_in, cfg_listen_len_in, cfg_gap_len_in;
    logic [BW-1:0] cfg_burst_in;
    logic          cfg_ready_out, trig_out, listen_out, busy_out, done_out;
    logic [BW-1:0] burst_idx_out;
`ifdef TRIG_SEQ_CONTINUOUS_EN
    logic          cont_mode_in;
`endif

    always #5 clk_in = ~clk_in;

    trig_sequencer dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .tick_in           (tick_in),
        .cfg_valid_in      (cfg_valid_in),
        .cfg_ready_out     (cfg_ready_out),
        .cfg_trig_len_in   (cfg_trig_len_in),
        .cfg_listen_len_in (cfg_listen_len_in),
        .cfg_gap_len_in    (cfg_gap_len_in),
        .cfg_burst_in      (cfg_burst_in),
        .start_in          (start_in),
        .abort_in          (abort_in),
`ifdef TRIG_SEQ_CONTINUOUS_EN
        .cont_mode_in      (cont_mode_in),
`endif
        .trig_out          (trig_out),
        .listen_out        (listen_out),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .burst_idx_out     (burst_idx_out)
    );

    int checks = 0;
    int failures = 0;
    int period = 1;
    int tick_ctr = 0;
    bit chk_en = 1'b0;
    int trig_cyc, listen_cyc, done_cyc, idle_cyc;

    // Reference model: phase 0 idle, 1 trig, 2 listen, 3 gap, 4 done.
    int m_phase, m_left, m_idx, m_trig, m_listen, m_gap, m_burst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nz(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Model advances at each rising edge from the inputs held since the falling edge.
    always @(posedge clk_in) begin
        if (!rst_in) begin
            m_phase = 0; m_idx = 0; m_left = 0;
            m_trig = 1; m_listen = 1; m_gap = 1; m_burst = 1;
        end else begin
            if (m_phase == 0 && !start_in && cfg_valid_in) begin
                m_trig   = nz(int'(cfg_trig_len_in));
                m_listen = nz(int'(cfg_listen_len_in));
                m_gap    = nz(int'(cfg_gap_len_in));
                m_burst  = nz(int'(cfg_burst_in));
            end
            if (abort_in && m_phase != 0) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (start_in) begin m_phase = 1; m_left = m_trig; m_idx = 0; end
            end else if (m_phase == 4) begin
                m_phase = 0;
`ifdef TRIG_SEQ_CONTINUOUS_EN
                if (cont_mode_in) begin m_phase = 1; m_left = m_trig; m_idx = 0; end
`endif
            end else if (tick_in) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_phase == 1) begin
                        m_phase = 2; m_left = m_listen;
                    end else if (m_phase == 2) begin
                        if (m_idx == m_burst - 1) m_phase = 4;
                        else begin m_phase = 3; m_left = m_gap; end
                    end else begin
                        m_phase = 1; m_left = m_trig; m_idx = m_idx + 1;
                    end
                end
            end
        end
    end

    // Compare DUT against the model shortly after each falling edge.
    initial begin
        forever begin
            @(negedge clk_in);
            #2;
            if (chk_en) begin
                chk("trig_out",   trig_out,   32'(m_phase == 1));
                chk("listen_out", listen_out, 32'(m_phase == 2));
                chk("busy_out",   busy_out,   32'(m_phase != 0));
                chk("done_out",   done_out,   32'(m_phase == 4));
                chk("burst_idx",  burst_idx_out, 32'(m_idx));
                chk("cfg_ready",  cfg_ready_out, 32'(m_phase == 0 && !start_in));
                if (trig_out === 1'b1)   trig_cyc++;
                if (listen_out === 1'b1) listen_cyc++;
                if (done_out === 1'b1)   done_cyc++;
                if (busy_out === 1'b0)   idle_cyc++;
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk_in);
        tick_ctr++;
        tick_in = ((tick_ctr % period) == 0);
    endtask

    task automatic clr_counts();
        trig_cyc = 0; listen_cyc = 0; done_cyc = 0; idle_cyc = 0;
    endtask

    task automatic set_cfg(input int t, input int l, input int g, input int b);
        next_cycle();
        cfg_trig_len_in = CW'(t); cfg_listen_len_in = CW'(l);
        cfg_gap_len_in = CW'(g); cfg_burst_in = BW'(b);
        cfg_valid_in = 1'b1;
        next_cycle();
        cfg_valid_in = 1'b0;
    endtask

    // Start on a cycle that carries a tick so the first phase tick is a full period later.
    task automatic start_burst();
        int n = 0;
        do begin next_cycle(); n++; end while (!tick_in && n < 64);
        start_in = 1'b1;
        next_cycle();
        start_in = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n = 0;
        while (busy_out !== 1'b0 && n < bound) begin next_cycle(); n++; end
        chk(nm, busy_out, 32'd0);
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (cfg_ready_out !== 1'b1 && n < 200) begin next_cycle(); n++; end
        chk(nm, busy_out, 32'd0);
        next_cycle();
        cfg_valid_in = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; tick_in = 1'b0; cfg_valid_in = 1'b0; start_in = 1'b0; abort_in = 1'b0;
        cfg_trig_len_in = '0; cfg_listen_len_in = '0; cfg_gap_len_in = '0; cfg_burst_in = '0;
`ifdef TRIG_SEQ_CONTINUOUS_EN
        cont_mode_in = 1'b0;
`endif
        clr_counts();
        next_cycle();
        next_cycle();
        chk_en = 1'b1;
        chk("rst_busy", busy_out, 32'd0);
        chk("rst_idx",  burst_idx_out, 32'd0);
        chk("rst_done", done_out, 32'd0);
        rst_in = 1'b1;

        // Basic two-shot burst, tick every 4 cycles.
        period = 4;
        set_cfg(2, 3, 1, 2);
        clr_counts();
        start_burst();
        wait_idle("t1_idle", 200);
        chk("t1_trig_cyc", trig_cyc, 32'd16);
        chk("t1_listen_cyc", listen_cyc, 32'd24);
        chk("t1_done_cyc", done_cyc, 32'd1);
        chk("t1_last_idx", burst_idx_out, 32'd1);

        // Zero config behaves as all ones.
        period = 1;
        set_cfg(0, 0, 0, 0);
        clr_counts();
        start_burst();
        wait_idle("t2_idle", 50);
        chk("t2_trig_cyc", trig_cyc, 32'd1);
        chk("t2_listen_cyc", listen_cyc, 32'd1);
        chk("t2_done_cyc", done_cyc, 32'd1);

        // Abort during second LISTEN of a 4-shot burst.
        set_cfg(1, 2, 1, 4);
        clr_counts();
        start_burst();
        begin
            int n = 0;
            while (!(listen_out === 1'b1 && burst_idx_out == BW'(1)) && n < 50) begin
                next_cycle(); n++;
            end
        end
        abort_in = 1'b1;
        next_cycle();
        abort_in = 1'b0;
        chk("t3_abort_busy", busy_out, 32'd0);
        chk("t3_abort_listen", listen_out, 32'd0);
        chk("t3_abort_idx", burst_idx_out, 32'd1);
        chk("t3_abort_done", done_cyc, 32'd0);
        clr_counts();
        start_burst();
        wait_idle("t3_rerun_idle", 100);
        chk("t3_rerun_done", done_cyc, 32'd1);
        chk("t3_rerun_idx", burst_idx_out, 32'd3);
        chk("t3_rerun_trig", trig_cyc, 32'd4);

        // Config held valid during a busy burst, accepted only in IDLE.
        start_burst();
        cfg_trig_len_in = CW'(3); cfg_listen_len_in = CW'(1);
        cfg_gap_len_in = CW'(1); cfg_burst_in = BW'(1);
        cfg_valid_in = 1'b1;
        wait_ready("t4_accept_idle");
        clr_counts();
        start_burst();
        wait_idle("t4_idle", 50);
        chk("t4_trig_cyc", trig_cyc, 32'd3);
        chk("t4_listen_cyc", listen_cyc, 32'd1);

        // Start and config in the same IDLE cycle, plus a start during TRIG.
        clr_counts();
        next_cycle();
        cfg_trig_len_in = CW'(2); cfg_valid_in = 1'b1; start_in = 1'b1;
        next_cycle();
        start_in = 1'b1;
        next_cycle();
        start_in = 1'b0;
        wait_ready("t5_accept_idle");
        chk("t5_old_trig_cyc", trig_cyc, 32'd3);
        chk("t5_done_cyc", done_cyc, 32'd1);
        clr_counts();
        start_burst();
        wait_idle("t5_idle", 50);
        chk("t5_new_trig_cyc", trig_cyc, 32'd2);

        // Reset during GAP restores idle outputs and unit config.
        set_cfg(1, 1, 5, 2);
        start_burst();
        begin
            int n = 0;
            while (m_phase != 3 && n < 50) begin next_cycle(); n++; end
        end
        next_cycle();
        rst_in = 1'b0;
        next_cycle();
        rst_in = 1'b1;
        chk("t6_rst_busy", busy_out, 32'd0);
        chk("t6_rst_trig", trig_out, 32'd0);
        chk("t6_rst_listen", listen_out, 32'd0);
        chk("t6_rst_done", done_out, 32'd0);
        chk("t6_rst_idx", burst_idx_out, 32'd0);
        clr_counts();
        start_burst();
        wait_idle("t6_idle", 50);
        chk("t6_trig_cyc", trig_cyc, 32'd1);
        chk("t6_listen_cyc", listen_cyc, 32'd1);
        chk("t6_done_cyc", done_cyc, 32'd1);

`ifdef TRIG_SEQ_CONTINUOUS_EN
        // Continuous mode: back-to-back bursts, abort returns to IDLE.
        cont_mode_in = 1'b1;
        start_burst();
        clr_counts();
        repeat (20) next_cycle();
        chk("t7_no_idle", idle_cyc, 32'd0);
        chk("t7_done_seen", 32'(done_cyc > 0), 32'd1);
        abort_in = 1'b1;
        next_cycle();
        abort_in = 1'b0;
        cont_mode_in = 1'b0;
        chk("t7_abort_busy", busy_out, 32'd0);
`endif

        repeat (3) next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trig_sequencer.md
Name: trig_sequencer

Overview:
- Sequences one depth-capture burst: emitter trigger pulse, receiver listen window, inter-shot gap, repeated a programmed number of times.
- All phase durations are counted in tick events, not clock cycles. `tick_in` comes from the shared prescaled event pulse.
- Sits between the host/config interface and the emitter/receiver front end of the peripheral FPGA.

Parameters:
- CNT_WIDTH, 16, width of each phase-length field and of the internal phase counter.
- BURST_WIDTH, 8, width of the burst-count field and of `burst_idx_out`.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- tick_in  input  1  one-cycle timebase event; phases advance only on this
- cfg_valid_in  input  1  config write strobe
- cfg_ready_out  output  1  config accepted when valid and ready are both high
- cfg_trig_len_in  input  CNT_WIDTH  trigger phase length in ticks
- cfg_listen_len_in  input  CNT_WIDTH  listen phase length in ticks
- cfg_gap_len_in  input  CNT_WIDTH  gap phase length in ticks
- cfg_burst_in  input  BURST_WIDTH  shots per burst
- start_in  input  1  start a burst (level-sampled)
- abort_in  input  1  cancel the burst in progress
- trig_out  output  1  high during TRIG
- listen_out  output  1  high during LISTEN
- busy_out  output  1  high in any state except IDLE
- done_out  output  1  one-cycle pulse when a burst completes
- burst_idx_out  output  BURST_WIDTH  index of the current shot, 0-based

Behaviour:
- Reset (`rst_in` == 0 at a clock edge):
  - state = IDLE; all outputs 0; `burst_idx_out` = 0.
  - All four config registers = 1.
  - Reset mid-burst behaves identically; no `done_out`.
- States: IDLE, TRIG, LISTEN, GAP, DONE.
- Outputs are registered and Moore-decoded from state; `cfg_ready_out` is the only combinational output.
- `cfg_ready_out` = (state == IDLE) && !`start_in`.
  - On handshake, all four fields are latched at once.
  - A length or burst value of 0 is stored as 1.
- IDLE → TRIG: on the edge where `start_in` == 1. Phase counter cleared; `burst_idx_out` = 0.
- Phase counter: increments on `tick_in`. A phase ends on the edge where `tick_in` == 1 and counter == len-1; the counter is then cleared.
  - Phase length L therefore spans exactly L ticks.
  - The phase is entered mid-tick-period, so the first tick may arrive after less than one full period.
- TRIG → LISTEN at end of TRIG.
- LISTEN at end of phase:
  - If `burst_idx_out` == burst-1: go to DONE.
  - Otherwise: go to GAP.
- GAP → TRIG at end of GAP; `burst_idx_out` += 1.
- DONE: `done_out` = 1 for exactly one cycle, then IDLE. `burst_idx_out` holds its last value until the next start.
- `start_in` while busy: ignored.
- `cfg_valid_in` while busy: not accepted (ready = 0); the sender must hold valid.
- `abort_in` has priority over start, tick and phase end.
  - In any non-IDLE state, the next state is IDLE, with `trig_out`/`listen_out` low the next cycle.
  - No `done_out` pulse.
  - `burst_idx_out` holds.
  - In IDLE, abort is a no-op.
- `tick_in` while in IDLE or DONE: ignored.
- Arithmetic: counters are unsigned and never wrap within a legal phase, since len ≤ 2^CNT_WIDTH-1.

Optional Feature:
- Macro: TRIG_SEQ_CONTINUOUS_EN.
- When defined:
  - Adds port `cont_mode_in` (input, 1).
  - In DONE with `cont_mode_in` == 1: still pulse `done_out`, then go to TRIG (not IDLE) with `burst_idx_out` = 0.
  - Abort still returns to IDLE.
- When undefined: the port is absent and DONE always goes to IDLE.

Decomposition:
- Package `trig_seq_pkg`:
  - state enum `trig_seq_state_t`.
  - Default widths (CNT_WIDTH_DEF = 16, BURST_WIDTH_DEF = 8).
- Sub-module `phase_timer`:
  - Inputs: `clk_in`, `rst_in`, `clr_in`, `tick_in`, `len_in`.
  - Output: `hit_out`, a combinational terminal-count pulse.
  - Instantiated once and shared by all phases.

Test Plan:
- Config trig=2, listen=3, gap=1, burst=2; tick every 4 cycles; start → `trig_out` high for 2 ticks, `listen_out` for 3, gap 1 tick, second shot with `burst_idx_out` = 1, one `done_out` pulse. Total high cycles: trig 16, listen 24.
- Config all lengths 0, burst 0, tick every cycle → behaves as lengths 1, burst 1: TRIG 1 cycle, LISTEN 1 cycle, DONE pulse, then IDLE.
- Abort asserted during the second LISTEN of a burst=4 run → IDLE next cycle, no `done_out`, `burst_idx_out` = 1 holds. A new start then runs cleanly from idx 0.
- `cfg_valid_in` held high during a busy burst → `cfg_ready_out` = 0 until IDLE; accepted on the first IDLE cycle. The next burst uses the new values.
- Start pulsed during TRIG, and start + `cfg_valid_in` asserted in the same IDLE cycle → mid-burst start ignored; the same-cycle config is not accepted, the start runs with the old config, and the config is accepted after DONE.
- With TRIG_SEQ_CONTINUOUS_EN defined, `cont_mode_in` = 1, burst=1 → `done_out` pulses every shot and no IDLE cycle occurs. Abort returns to IDLE.
- Reset mid-GAP → all outputs 0 the next cycle and config back to 1s.
